// File: rtl/mult_seq_datapath_pkg.sv
// mult_pkg: shift codes, step limit and control FSM state codes shared by the multiplier datapath and its FSM
package mult_pkg;
  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_HALF = 2'b01;
  localparam logic [1:0] SHIFT_FULL = 2'b10;
  localparam logic [2:0] STEP_LAST  = 3'd4;
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, FINISH = 3'd4} state_t;
  function automatic logic shift_legal(input logic [1:0] sel);
    return sel != 2'b11;
  endfunction
endpackage

// File: rtl/mult_partial.sv
// mult_partial: slice mux, HALFxHALF unsigned multiply and shift into a 2*WIDTH partial
module mult_partial
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               sela,
  input  logic               selb,
  input  logic [1:0]         sel_shifter,
  output logic [2*WIDTH-1:0] partial,
  output logic               illegal
);
  localparam int HALF = WIDTH / 2;
  logic [HALF-1:0]    a, b;
  logic [WIDTH-1:0]   p;
  logic [2*WIDTH-1:0] pe;
  always_comb begin
    a       = sela ? opa[WIDTH-1:HALF] : opa[HALF-1:0];
    b       = selb ? opb[WIDTH-1:HALF] : opb[HALF-1:0];
    p       = a * b;
    pe      = {{WIDTH{1'b0}}, p};
    illegal = !shift_legal(sel_shifter);
    partial = illegal                    ? '0 :
              sel_shifter == SHIFT_FULL  ? pe << WIDTH :
              sel_shifter == SHIFT_HALF  ? pe << HALF : pe;
  end
endmodule

// File: rtl/mult_seq_datapath.sv
// mult_seq_datapath: operand capture, step counter, accumulator and sticky shift-error flag for the 4-step multiplier
module mult_seq_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  input  logic               sela,
  input  logic               selb,
  input  logic [1:0]         sel_shifter,
  input  logic               done_flag,
  output logic [2:0]         count,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_valid,
  output logic               sel_err
);
  logic [WIDTH-1:0]   opa, opb;
  logic [2*WIDTH-1:0] partial;
  logic               illegal;
  mult_partial #(.WIDTH(WIDTH)) u_partial (
    .opa         (opa),
    .opb         (opb),
    .sela        (sela),
    .selb        (selb),
    .sel_shifter (sel_shifter),
    .partial     (partial),
    .illegal     (illegal)
  );
  // counting stops at STEP_LAST so the result holds while start stays high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      product <= '0;
      opa     <= '0;
      opb     <= '0;
      sel_err <= 1'b0;
    end else if (!start) begin
      count   <= '0;
      product <= '0;
      opa     <= dataa;
      opb     <= datab;
    end else if (count != STEP_LAST) begin
      count   <= count + 3'd1;
      product <= product + partial;
      if (illegal) sel_err <= 1'b1;
    end
  end
  assign prod_valid = done_flag && count == STEP_LAST;
endmodule

// File: tb/tb_mult_seq_datapath.sv
// tb_mult_seq_datapath: directed vector table plus hand sequences for reset, abort, illegal shift and operand hold
module tb_mult_seq_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dataa = '0, datab = '0;
  logic        sela = 1'b0, selb = 1'b0;
  logic [1:0]  sel_shifter = 2'b00;
  logic        done_flag = 1'b0;
  logic [2:0]  count;
  logic [15:0] product;
  logic        prod_valid, sel_err;
  int errors = 0, checks = 0;

  mult_seq_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dataa(dataa), .datab(datab),
    .sela(sela), .selb(selb), .sel_shifter(sel_shifter), .done_flag(done_flag),
    .count(count), .product(product), .prod_valid(prod_valid), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    start = 1'b0; done_flag = 1'b0;
    dataa = a; datab = b;
    tick();
  endtask

  // FSM order: hi*hi<<8, hi*lo<<4, lo*hi<<4, lo*lo
  task automatic step(input int s, input logic [1:0] sh);
    start = 1'b1;
    sela = (s < 2);
    selb = (s == 0 || s == 2);
    sel_shifter = sh;
    tick();
  endtask

  function automatic logic [1:0] shift_of(input int s);
    return s == 0 ? 2'b10 : (s == 3 ? 2'b00 : 2'b01);
  endfunction

  task automatic finish_op();
    done_flag = 1'b1;
    sela = 1'($urandom); selb = 1'($urandom); sel_shifter = 2'($urandom);
  endtask

  vec_t vecs[8];
  logic [15:0] hold;

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'h03, 8'h05, 16'h000F};
    vecs[3] = '{8'h00, 8'hFF, 16'h0000};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'hA5, 8'h5A, 16'h3A02};
    vecs[6] = '{8'h01, 8'h01, 16'h0001};
    vecs[7] = '{8'hFF, 8'h01, 16'h00FF};

    #12;
    check("reset_count", 32'(count), 0);
    check("reset_product", 32'(product), 0);
    check("reset_sel_err", 32'(sel_err), 0);
    check("reset_valid", 32'(prod_valid), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load(vecs[i].a, vecs[i].b);
      for (int s = 0; s < 4; s++) begin
        if (s == 3) check($sformatf("v%0d_valid_early", i), 32'(prod_valid), 0);
        step(s, shift_of(s));
      end
      finish_op();
      #1;
      check($sformatf("v%0d_product", i), 32'(product), 32'(vecs[i].exp));
      check($sformatf("v%0d_count", i), 32'(count), 4);
      check($sformatf("v%0d_valid", i), 32'(prod_valid), 1);
      tick();
      tick();
      check($sformatf("v%0d_hold", i), 32'(product), 32'(vecs[i].exp));
      check($sformatf("v%0d_hold_count", i), 32'(count), 4);
    end

    // running sums for 12*34
    load(8'h12, 8'h34);
    step(0, 2'b10); check("p1234_s0", 32'(product), 32'h0300);
    step(1, 2'b01); check("p1234_s1", 32'(product), 32'h0340);
    step(2, 2'b01); check("p1234_s2", 32'(product), 32'h03A0);
    step(3, 2'b00); check("p1234_s3", 32'(product), 32'h03A8);

    // illegal shift at count=1
    load(8'hFF, 8'hFF);
    check("err_before", 32'(sel_err), 0);
    step(0, 2'b10);
    step(1, 2'b11);
    check("err_set", 32'(sel_err), 1);
    step(2, 2'b01);
    step(3, 2'b00);
    finish_op();
    #1;
    check("err_count", 32'(count), 4);
    check("err_product", 32'(product), 32'hEFF1);
    load(8'h03, 8'h05);
    check("err_sticky", 32'(sel_err), 1);

    // async reset mid-run at count=2
    step(0, 2'b10);
    step(1, 2'b01);
    check("rst_pre_count", 32'(count), 2);
    #2 rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_product", 32'(product), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    #1 rst = 1'b1;

    // abort after two run cycles, then rerun
    load(8'hFF, 8'hFF);
    step(0, 2'b10);
    step(1, 2'b01);
    check("abort_mid", 32'(product), 32'hEF10);
    load(8'h03, 8'h05);
    check("abort_count", 32'(count), 0);
    check("abort_product", 32'(product), 0);
    for (int s = 0; s < 4; s++) step(s, shift_of(s));
    finish_op();
    #1;
    check("rerun_product", 32'(product), 32'h000F);
    check("rerun_valid", 32'(prod_valid), 1);

    // operands change during the run
    load(8'h12, 8'h34);
    for (int s = 0; s < 4; s++) begin
      dataa = 8'($urandom); datab = 8'($urandom);
      step(s, shift_of(s));
      if (s < 3) check($sformatf("chg_valid_%0d", s), 32'(prod_valid), 0);
    end
    finish_op();
    #1;
    check("chg_product", 32'(product), 32'h03A8);
    check("chg_valid", 32'(prod_valid), 1);
    hold = product;
    dataa = 8'h00; datab = 8'h00;
    tick();
    check("chg_hold", 32'(product), 32'(hold));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
